// File: rtl/perlin_pkg.sv
// Shared constants for the gradient-noise pipeline: permutation table,
// gradient encoding and the small arithmetic helpers used by the stages.
package perlin_pkg;

   // Ken Perlin's reference permutation.
   localparam logic [7:0] P [256] = '{
      151,160,137, 91, 90, 15,131, 13,201, 95, 96, 53,194,233,  7,225,
      140, 36,103, 30, 69,142,  8, 99, 37,240, 21, 10, 23,190,  6,148,
      247,120,234, 75,  0, 26,197, 62, 94,252,219,203,117, 35, 11, 32,
       57,177, 33, 88,237,149, 56, 87,174, 20,125,136,171,168, 68,175,
       74,165, 71,134,139, 48, 27,166, 77,146,158,231, 83,111,229,122,
       60,211,133,230,220,105, 92, 41, 55, 46,245, 40,244,102,143, 54,
       65, 25, 63,161,  1,216, 80, 73,209, 76,132,187,208, 89, 18,169,
      200,196,135,130,116,188,159, 86,164,100,109,198,173,186,  3, 64,
       52,217,226,250,124,123,  5,202, 38,147,118,126,255, 82, 85,212,
      207,206, 59,227, 47, 16, 58, 17,182,189, 28, 42,223,183,170,213,
      119,248,152,  2, 44,154,163, 70,221,153,101,155,167, 43,172,  9,
      129, 22, 39,253, 19, 98,108,110, 79,113,224,232,178,185,112,104,
      218,246, 97,228,251, 34,242,193,238,210,144, 12,191,179,162,241,
       81, 51,145,235,249, 14,239,107, 49,192,214, 31,181,199,106,157,
      184, 84,204,176,115,121, 50, 45,127,  4,150,254,138,236,205, 93,
      222,114, 67, 29, 24, 72,243,141,128,195, 78, 66,215, 61,156,180
   };

   // Gradient select from the low two hash bits: bit0 negates gx, bit1 negates gy.
   localparam logic [1:0] GRAD_PP = 2'd0;
   localparam logic [1:0] GRAD_NP = 2'd1;
   localparam logic [1:0] GRAD_PN = 2'd2;
   localparam logic [1:0] GRAD_NN = 2'd3;

   // Smoothstep fade of a cell fraction f in 0..S-1, result in 0..S-1.
   function automatic int fade(input int f, input int cl);
      return (f * f * (3 * (1 << cl) - 2 * f)) >>> (2 * cl);
   endfunction

   // Dot product of the hashed gradient with the corner offset.
   function automatic int grad_dot(input logic [7:0] h, input int dx, input int dy);
      case (h[1:0])
         GRAD_PP: return  dx + dy;
         GRAD_NP: return -dx + dy;
         GRAD_PN: return  dx - dy;
         default: return -dx - dy;
      endcase
   endfunction

   // Fixed-point interpolation, t scaled by 2**cl, floor rounding.
   function automatic int lerp(input int t, input int a, input int b, input int cl);
      return a + (((b - a) * t) >>> cl);
   endfunction

endpackage

// File: rtl/perlin_perm_rom.sv
// Combinational 8b -> 8b permutation lookup.
module perlin_perm_rom
   import perlin_pkg::*;
(
   input  logic [7:0] addr,
   output logic [7:0] data
);

   assign data = P[addr];

endmodule

// File: rtl/perlin_noise_pipe.sv
// Six-stage 2-D gradient noise pipeline with frame-driven scrolling.
// One sample per clock, fixed latency, no backpressure.
module perlin_noise_pipe
   import perlin_pkg::*;
#(
   parameter int          COORD_W   = 10,
   parameter int          CELL_LOG2 = 5,
   parameter int          OUT_W     = 8,
   parameter int unsigned SPEED_X   = 0,
   parameter int unsigned SPEED_Y   = 1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [7:0]         seed,
   input  logic               frame_tick,
   output logic               out_valid,
   output logic [OUT_W-1:0]   noise
);

   localparam int CL     = CELL_LOG2;
   localparam int S      = 1 << CL;
   localparam int EW     = CL + 8;          // extended coordinate, 256-cell period
   localparam int FW     = CL + 1;          // fade weight
   localparam int DW     = CL + 3;          // signed dot / lerp result
   localparam int STAGES = 6;
   localparam int MID    = 1 << (OUT_W - 1);
   localparam int NMAX   = (1 << OUT_W) - 1;

   logic [STAGES:1] vld_pipe;
   logic [EW-1:0]   off_x, off_y;

   // Scroll offsets advance once per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_x <= '0;
         off_y <= '0;
      end else if (frame_tick) begin
         off_x <= off_x + EW'(SPEED_X);
         off_y <= off_y + EW'(SPEED_Y);
      end
   end

   // Stage valids shift alongside the data; bubbles pass through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
   end

   assign out_valid = vld_pipe[STAGES];

   // ---------------- S1: scroll, split into cell and fraction, fade
   logic [EW-1:0]   ex, ey;
   logic [FW-1:0]   u_c, v_c;
   logic [7:0]      cx1, cy1, seed1;
   logic [CL-1:0]   fx1, fy1;
   logic [FW-1:0]   u1, v1;

   // Pre-tick offsets are used, so a coincident frame_tick only affects later samples.
   assign ex  = EW'(x) + off_x;
   assign ey  = EW'(y) + off_y;
   assign u_c = FW'(fade(int'(ex[CL-1:0]), CL));
   assign v_c = FW'(fade(int'(ey[CL-1:0]), CL));

   // S1 register: seed travels with its sample so changes never glitch in-flight data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx1 <= '0; cy1 <= '0; seed1 <= '0;
         fx1 <= '0; fy1 <= '0; u1 <= '0; v1 <= '0;
      end else if (in_valid) begin
         cx1   <= ex[EW-1:CL];
         cy1   <= ey[EW-1:CL];
         fx1   <= ex[CL-1:0];
         fy1   <= ey[CL-1:0];
         u1    <= u_c;
         v1    <= v_c;
         seed1 <= seed;
      end
   end

   // ---------------- S2: column hashes
   logic [7:0]    ha_c, hb_c, ha2, hb2, cy2;
   logic [CL-1:0] fx2, fy2;
   logic [FW-1:0] u2, v2;

   perlin_perm_rom u_rom_a (.addr(cx1 ^ seed1),         .data(ha_c));
   perlin_perm_rom u_rom_b (.addr((cx1 + 8'd1) ^ seed1), .data(hb_c));

   // S2 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ha2 <= '0; hb2 <= '0; cy2 <= '0;
         fx2 <= '0; fy2 <= '0; u2 <= '0; v2 <= '0;
      end else if (vld_pipe[1]) begin
         ha2 <= ha_c; hb2 <= hb_c; cy2 <= cy1;
         fx2 <= fx1;  fy2 <= fy1;  u2  <= u1;  v2 <= v1;
      end
   end

   // ---------------- S3: corner hashes, index k = {dy, dx}: 00, 10, 01, 11
   logic [3:0][7:0] h_c, h3;
   logic [CL-1:0]   fx3, fy3;
   logic [FW-1:0]   u3, v3;

   for (genvar k = 0; k < 4; k++) begin : g_corner_hash
      localparam logic [7:0] DY = 8'(k / 2);
      perlin_perm_rom u_rom_h (
         .addr((((k % 2) != 0) ? hb2 : ha2) + cy2 + DY),
         .data(h_c[k])
      );
   end

   // S3 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h3 <= '0; fx3 <= '0; fy3 <= '0; u3 <= '0; v3 <= '0;
      end else if (vld_pipe[2]) begin
         h3 <= h_c; fx3 <= fx2; fy3 <= fy2; u3 <= u2; v3 <= v2;
      end
   end

   // ---------------- S4: gradient dot products at the four corners
   logic [3:0][DW-1:0] d_c, d4;
   logic [FW-1:0]      u4, v4;

   for (genvar k = 0; k < 4; k++) begin : g_corner_dot
      localparam int OX = (k % 2) * S;
      localparam int OY = (k / 2) * S;
      assign d_c[k] = DW'(grad_dot(h3[k], int'(fx3) - OX, int'(fy3) - OY));
   end

   // S4 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d4 <= '0; u4 <= '0; v4 <= '0;
      end else if (vld_pipe[3]) begin
         d4 <= d_c; u4 <= u3; v4 <= v3;
      end
   end

   // ---------------- S5: horizontal interpolation
   logic [DW-1:0] n0_c, n1_c, n0_5, n1_5;
   logic [FW-1:0] v5;

   assign n0_c = DW'(lerp(int'(u4), int'($signed(d4[0])), int'($signed(d4[1])), CL));
   assign n1_c = DW'(lerp(int'(u4), int'($signed(d4[2])), int'($signed(d4[3])), CL));

   // S5 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n0_5 <= '0; n1_5 <= '0; v5 <= '0;
      end else if (vld_pipe[4]) begin
         n0_5 <= n0_c; n1_5 <= n1_c; v5 <= v4;
      end
   end

   // ---------------- S6: vertical interpolation, rescale to OUT_W, saturate
   int               n6, val6;
   logic [OUT_W-1:0] noise_c;

   // Scale n from +-S range to +-2**(OUT_W-1) around mid-scale, then clamp.
   always_comb begin
      n6      = lerp(int'(v5), int'($signed(n0_5)), int'($signed(n1_5)), CL);
      val6    = MID + ((n6 <<< (OUT_W - 1)) >>> CL);
      noise_c = '0;
      if (val6 > NMAX)   noise_c = OUT_W'(NMAX);
      else if (val6 > 0) noise_c = OUT_W'(val6);
   end

   // Output register holds its value across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           noise <= '0;
      else if (vld_pipe[5]) noise <= noise_c;
   end

endmodule

// File: tb/tb_perlin_noise_pipe.sv
// Self-checking bench for perlin_noise_pipe (default parameters, S=32).
module tb_perlin_noise_pipe;
   import perlin_pkg::*;

   localparam int S    = 32;
   localparam int EMOD = 8192;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic [7:0] seed = '0;
   logic       frame_tick = 1'b0;
   logic       out_valid;
   logic [7:0] noise;

   perlin_noise_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .seed(seed),
      .frame_tick(frame_tick), .out_valid(out_valid), .noise(noise)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0;
   int m_ox = 0, m_oy = 0;
   int exp_q[$], drv_c[$], obs_n[$], obs_c[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         obs_n.push_back(int'(noise));
         obs_c.push_back(cyc);
      end
   end

   // ---------------- reference model, plain integer arithmetic
   function automatic int fdiv(int n, int d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   function automatic int corner(int h, int dx, int dy);
      int gx = ((h % 2) == 1) ? -1 : 1;
      int gy = (((h / 2) % 2) == 1) ? -1 : 1;
      return gx * dx + gy * dy;
   endfunction

   function automatic int model(int xv, int yv, int sv, int ox, int oy);
      int ex = (xv + ox) % EMOD, ey = (yv + oy) % EMOD;
      int cx = ex / S, fx = ex % S, cy = ey / S, fy = ey % S;
      int u = fx * fx * (3 * S - 2 * fx) / (S * S);
      int v = fy * fy * (3 * S - 2 * fy) / (S * S);
      int ha = P[cx ^ sv], hb = P[((cx + 1) % 256) ^ sv];
      int h00 = P[(ha + cy) % 256], h10 = P[(hb + cy) % 256];
      int h01 = P[(ha + cy + 1) % 256], h11 = P[(hb + cy + 1) % 256];
      int d00 = corner(h00, fx, fy),     d10 = corner(h10, fx - S, fy);
      int d01 = corner(h01, fx, fy - S), d11 = corner(h11, fx - S, fy - S);
      int n0 = d00 + fdiv((d10 - d00) * u, S);
      int n1 = d01 + fdiv((d11 - d01) * u, S);
      int n  = n0 + fdiv((n1 - n0) * v, S);
      int r  = 128 + fdiv(n * 128, S);
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   // ---------------- stimulus helpers
   task automatic drive(int xv, int yv, int sv, bit tk, bit vl);
      x = 10'(xv); y = 10'(yv); seed = 8'(sv); frame_tick = tk; in_valid = vl;
      if (vl) begin
         exp_q.push_back(model(xv, yv, sv, m_ox, m_oy));
         drv_c.push_back(cyc);
      end
      if (tk) begin
         m_ox = (m_ox + 0) % EMOD;
         m_oy = (m_oy + 1) % EMOD;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic clear_q();
      exp_q.delete(); drv_c.delete(); obs_n.delete(); obs_c.delete();
   endtask

   task automatic drain();
      int b = 0;
      while (obs_n.size() < exp_q.size() && b < 30) begin
         @(posedge clk); #1; b++;
      end
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      m_ox = 0; m_oy = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_q();
   endtask

   // ---------------- tests
   task automatic test_reset();
      #12;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (noise !== 8'd0) begin bad++; $display("FAIL reset_noise got=%0d want=0", noise); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_q();
   endtask

   task automatic test_latency();
      clear_q();
      drive(0, 0, 0, 0, 1);
      repeat (10) begin @(posedge clk); #1; end
      total++; if (obs_n.size() != 1) begin bad++; $display("FAIL latency_count got=%0d want=1", obs_n.size()); end
      if (obs_n.size() >= 1) begin
         total++; if (obs_c[0] - drv_c[0] != 6) begin bad++; $display("FAIL latency_cycles got=%0d want=6", obs_c[0] - drv_c[0]); end
         total++; if (obs_n[0] != 128) begin bad++; $display("FAIL latency_noise got=%0d want=128", obs_n[0]); end
      end
   endtask

   task automatic test_lattice();
      clear_q();
      for (int yi = 0; yi < 15; yi++)
         for (int xi = 0; xi < 20; xi++)
            drive(xi * 32, yi * 32, int'($urandom_range(0, 255)), 0, 1);
      drain();
      total++; if (obs_n.size() != 300) begin bad++; $display("FAIL lattice_count got=%0d want=300", obs_n.size()); end
      foreach (obs_n[i]) begin
         total++; if (obs_n[i] != 128) begin bad++; $display("FAIL lattice_noise idx=%0d got=%0d want=128", i, obs_n[i]); end
      end
   endtask

   task automatic test_stream();
      clear_q();
      for (int i = 0; i < 640; i++) drive(i, 100, 8'h5A, 0, 1);
      drain();
      total++; if (obs_n.size() != 640) begin bad++; $display("FAIL stream_count got=%0d want=640", obs_n.size()); end
      foreach (obs_n[i]) begin
         if (i < exp_q.size()) begin
            total++; if (obs_n[i] != exp_q[i]) begin bad++; $display("FAIL stream_noise idx=%0d got=%0d want=%0d", i, obs_n[i], exp_q[i]); end
            total++; if (obs_c[i] - obs_c[0] != i) begin bad++; $display("FAIL stream_gap idx=%0d got=%0d want=%0d", i, obs_c[i] - obs_c[0], i); end
         end
      end
   endtask

   task automatic test_scroll();
      do_reset();
      repeat (3) drive(0, 0, 0, 1, 0);
      drive(0, 29, 0, 0, 1);
      drive(0, 29, 0, 1, 1);
      drive(0, 29, 0, 0, 1);
      drain();
      total++; if (obs_n.size() != 3) begin bad++; $display("FAIL scroll_count got=%0d want=3", obs_n.size()); end
      if (obs_n.size() == 3) begin
         total++; if (obs_n[0] != 128) begin bad++; $display("FAIL scroll_after3 got=%0d want=128", obs_n[0]); end
         total++; if (obs_n[1] != 128) begin bad++; $display("FAIL scroll_coincident got=%0d want=128", obs_n[1]); end
         total++; if (obs_n[2] != exp_q[2]) begin bad++; $display("FAIL scroll_after4 got=%0d want=%0d", obs_n[2], exp_q[2]); end
      end
   endtask

   task automatic test_random();
      clear_q();
      for (int i = 0; i < 400; i++)
         drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0));
      drain();
      total++; if (obs_n.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d want=%0d", obs_n.size(), exp_q.size()); end
      foreach (obs_n[i]) begin
         if (i < exp_q.size()) begin
            total++; if (obs_n[i] != exp_q[i]) begin bad++; $display("FAIL random_noise idx=%0d got=%0d want=%0d", i, obs_n[i], exp_q[i]); end
         end
      end
      if (exp_q.size() > 0) begin
         total++; if (out_valid !== 1'b0 || int'(noise) != exp_q[$]) begin
            bad++; $display("FAIL hold got=%0d/%b want=%0d/0", noise, out_valid, exp_q[$]);
         end
      end
   endtask

   task automatic test_mid_reset();
      clear_q();
      repeat (3) drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) drive(i * 7, 29, int'($urandom_range(0, 255)), 0, 1);
      total++; if (out_valid !== 1'b1 || int'(noise) != exp_q[0]) begin
         bad++; $display("FAIL midrst_first got=%0d/%b want=%0d/1", noise, out_valid, exp_q[0]);
      end
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
      total++; if (noise !== 8'd0) begin bad++; $display("FAIL midrst_noise got=%0d want=0", noise); end
      @(posedge clk); #4;
      rst_n = 1'b1;
      m_ox = 0; m_oy = 0;
      clear_q();
      repeat (12) begin @(posedge clk); #1; end
      total++; if (obs_n.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", obs_n.size()); end
      drive(0, 29, 0, 0, 1);
      drain();
      total++; if (obs_n.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", obs_n.size()); end
      if (obs_n.size() == 1) begin
         total++; if (obs_n[0] != exp_q[0]) begin bad++; $display("FAIL midrst_offset got=%0d want=%0d", obs_n[0], exp_q[0]); end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (8191) drive(0, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 1);
      drive(int'($urandom_range(0, 1023)), 1, int'($urandom_range(0, 255)), 0, 1);
      drive(int'($urandom_range(0, 1023)), 0, int'($urandom_range(0, 255)), 0, 1);
      drive(int'($urandom_range(0, 1023)), 30, int'($urandom_range(0, 255)), 0, 1);
      drain();
      total++; if (obs_n.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", obs_n.size()); end
      if (obs_n.size() == 4) begin
         total++; if (obs_n[0] != 128) begin bad++; $display("FAIL wrap_lattice got=%0d want=128", obs_n[0]); end
         for (int i = 1; i < 4; i++) begin
            total++; if (obs_n[i] != exp_q[i]) begin bad++; $display("FAIL wrap_noise idx=%0d got=%0d want=%0d", i, obs_n[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_lattice();
      test_stream();
      test_scroll();
      test_random();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
